// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: LFSR-driven hole selection, per-mole lifetime by
// difficulty level, hidden gap between moles, and hit/miss event pulses.
module mole_scheduler #(
    parameter int unsigned       NUM_HOLES   = 5,
    parameter int unsigned       HOLE_W      = $clog2(NUM_HOLES),
    parameter int unsigned       LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
    parameter int unsigned       BASE_PERIOD = 100000000,
    parameter int unsigned       GAP_CYCLES  = 25000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_restart_game,
    input  logic              i_game_over,
    input  logic [1:0]        i_level,
    input  logic              i_hit,
    input  logic [HOLE_W-1:0] i_hit_pos,
    output logic [HOLE_W-1:0] o_mole_position,
    output logic              o_mole_valid,
    output logic              o_position_changed,
    output logic              o_hit_ok,
    output logic              o_hit_bad,
    output logic              o_miss
);

    localparam int unsigned MAX_CNT = (BASE_PERIOD > GAP_CYCLES) ? BASE_PERIOD : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHOW,
        HALT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] lfsr_step;
    logic [HOLE_W-1:0] pos_q, pos_d;
    logic [HOLE_W-1:0] cand;
    logic [HOLE_W-1:0] spawn_pos;
    logic              valid_q, valid_d;
    logic              changed_q, changed_d;
    logic              ok_q, ok_d;
    logic              bad_q, bad_d;
    logic              miss_q, miss_d;

    // Next LFSR value and the non-repeating spawn hole derived from the current one
    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_step = SEED;
        end else if (lfsr_q[0]) begin
            lfsr_step = (lfsr_q >> 1) ^ TAPS;
        end else begin
            lfsr_step = lfsr_q >> 1;
        end
        cand      = HOLE_W'(lfsr_q % LFSR_W'(NUM_HOLES));
        spawn_pos = (cand == pos_q) ? HOLE_W'((32'(cand) + 32'd1) % NUM_HOLES) : cand;
    end

    // Next-state and registered-output logic; pos_q doubles as the previous hole
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        lfsr_d    = lfsr_q;
        pos_d     = pos_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        ok_d      = 1'b0;
        bad_d     = 1'b0;
        miss_d    = 1'b0;

        if (i_restart_game) begin
            state_d = GAP;
            cnt_d   = '0;
            valid_d = 1'b0;
            lfsr_d  = lfsr_step;
        end else if (i_game_over || (state_q == HALT)) begin
            state_d = HALT;
            valid_d = 1'b0;
        end else begin
            lfsr_d = lfsr_step;
            case (state_q)
                IDLE: begin
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        pos_d     = spawn_pos;
                        valid_d   = 1'b1;
                        changed_d = 1'b1;
                        period_d  = CNT_W'(BASE_PERIOD >> i_level);
                        cnt_d     = '0;
                        state_d   = SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (i_hit && (i_hit_pos == pos_q)) begin
                        ok_d    = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        bad_d = i_hit;
                        if (cnt_q == period_q - CNT_W'(1)) begin
                            miss_d  = 1'b1;
                            valid_d = 1'b0;
                            cnt_d   = '0;
                            state_d = GAP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            lfsr_q    <= SEED;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            lfsr_q    <= lfsr_d;
            pos_q     <= pos_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
            miss_q    <= miss_d;
        end
    end

    assign o_mole_position    = pos_q;
    assign o_mole_valid       = valid_q;
    assign o_position_changed = changed_q;
    assign o_hit_ok           = ok_q;
    assign o_hit_bad          = bad_q;
    assign o_miss             = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_mole_scheduler;

    localparam int K_SPAWN = 0;
    localparam int K_OK    = 1;
    localparam int K_BAD   = 2;
    localparam int K_MISS  = 3;

    typedef struct {
        int kind;
        int pos;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       game_over;
    logic [1:0] level;
    logic       hit;
    logic [2:0] hit_pos;
    logic [2:0] mole_pos;
    logic       mole_valid;
    logic       pos_changed;
    logic       hit_ok;
    logic       hit_bad;
    logic       miss;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_n = 0;
    ev_t        exp_q[$];
    logic [15:0] lfsr_m;
    logic       halt_m;
    int         prev_m;
    int         mon_last;

    mole_scheduler #(
        .NUM_HOLES  (5),
        .LFSR_W     (16),
        .TAPS       (16'hB400),
        .SEED       (16'hACE1),
        .BASE_PERIOD(16),
        .GAP_CYCLES (4)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_restart_game    (restart),
        .i_game_over       (game_over),
        .i_level           (level),
        .i_hit             (hit),
        .i_hit_pos         (hit_pos),
        .o_mole_position   (mole_pos),
        .o_mole_valid      (mole_valid),
        .o_position_changed(pos_changed),
        .o_hit_ok          (hit_ok),
        .o_hit_bad         (hit_bad),
        .o_miss            (miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Bench-side LFSR tracker: frozen on game-over edges and while halted
    always @(posedge clk) begin
        if (!rst_n) begin
            lfsr_m <= 16'hACE1;
            halt_m <= 1'b0;
        end else if (restart) begin
            halt_m <= 1'b0;
            lfsr_m <= nxt(lfsr_m);
        end else if (game_over || halt_m) begin
            halt_m <= 1'b1;
        end else begin
            lfsr_m <= nxt(lfsr_m);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic pop_cmp(input int k);
        ev_t e;
        check("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_edge", edge_n, e.at);
            if (k == K_SPAWN) begin
                check("spawn_pos", int'(mole_pos), e.pos);
                check("spawn_no_repeat", int'(int'(mole_pos) != mon_last), 1);
                mon_last = int'(mole_pos);
            end
        end
    endtask

    // Monitor: compare every DUT pulse against the head of the expected queue
    always @(negedge clk) begin
        if (!rst_n) mon_last = 0;
        if (pos_changed) pop_cmp(K_SPAWN);
        if (hit_ok)      pop_cmp(K_OK);
        if (hit_bad)     pop_cmp(K_BAD);
        if (miss)        pop_cmp(K_MISS);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int k, input int p, input int at);
        ev_t e;
        e.kind = k;
        e.pos  = p;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Called the cycle after the counter was cleared into GAP; returns spawn edge and period
    task automatic await_spawn(input logic [1:0] lvl, output int s, output int period);
        int cand;
        int pos;
        int e0;
        level = lvl;
        e0 = edge_n;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("valid_in_gap", int'(mole_valid), 0);
            check("pos_hold", int'(mole_pos), prev_m);
        end
        cand = int'(lfsr_m) % 5;
        pos = (cand == prev_m) ? (cand + 1) % 5 : cand;
        push(K_SPAWN, pos, e0 + 4);
        prev_m = pos;
        tick();
        s = edge_n;
        period = 16 >> lvl;
        check("valid_after_spawn", int'(mole_valid), 1);
    endtask

    task automatic expire(input int s, input int period, input bit rnd_lvl);
        push(K_MISS, 0, s + period);
        while (edge_n < s + period) begin
            if (rnd_lvl) level = 2'($urandom_range(0, 3));
            check("valid_in_show", int'(mole_valid), 1);
            tick();
        end
        check("valid_after_miss", int'(mole_valid), 0);
    endtask

    task automatic do_hit(input int p, input bit correct);
        hit = 1'b1;
        hit_pos = 3'(p);
        push(correct ? K_OK : K_BAD, 0, edge_n + 1);
        tick();
        hit = 1'b0;
        check(correct ? "valid_after_hit" : "valid_after_bad_hit", int'(mole_valid), correct ? 0 : 1);
    endtask

    task automatic ticks_to(input int target);
        while (edge_n < target) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int s;
        int p;
        rst_n = 1'b0;
        restart = 1'b0;
        game_over = 1'b0;
        level = 2'd0;
        hit = 1'b0;
        hit_pos = 3'd0;
        prev_m = 0;
        mon_last = 0;
        tick();
        tick();
        check("rst_pos", int'(mole_pos), 0);
        check("rst_valid", int'(mole_valid), 0);
        check("rst_changed", int'(pos_changed), 0);
        check("rst_ok", int'(hit_ok), 0);
        check("rst_bad", int'(hit_bad), 0);
        check("rst_miss", int'(miss), 0);

        // Restart directly after reset: first hole is 0xACE1 stepped four times = 0x1C4E, mod 5 = 1
        rst_n = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        await_spawn(2'd0, s, p);
        check("first_pos", int'(mole_pos), 1);
        expire(s, p, 1'b0);

        // Wrong hole at counter 2, correct hole at counter 5
        await_spawn(2'd0, s, p);
        ticks_to(s + 2);
        do_hit((prev_m + 1) % 5, 1'b0);
        ticks_to(s + 5);
        do_hit(prev_m, 1'b1);

        // Correct hit on the timeout edge wins over the miss
        await_spawn(2'd0, s, p);
        ticks_to(s + 15);
        do_hit(prev_m, 1'b1);

        // Wrong hit alone leaves the lifetime unchanged
        await_spawn(2'd0, s, p);
        ticks_to(s + 3);
        do_hit((prev_m + 4) % 5, 1'b0);
        expire(s, p, 1'b0);

        // Long run with random levels, level also wiggled mid-life
        for (int i = 0; i < 200; i++) begin
            await_spawn(2'($urandom_range(0, 3)), s, p);
            expire(s, p, 1'b1);
        end

        // Game over mid-show freezes everything until restart
        await_spawn(2'd0, s, p);
        ticks_to(s + 3);
        game_over = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("valid_game_over", int'(mole_valid), 0);
        end
        game_over = 1'b0;
        tick();
        tick();
        check("valid_halt_hold", int'(mole_valid), 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        await_spawn(2'd2, s, p);
        expire(s, p, 1'b0);

        // Reset dominates a simultaneous restart mid-show
        await_spawn(2'd0, s, p);
        ticks_to(s + 5);
        rst_n = 1'b0;
        restart = 1'b1;
        prev_m = 0;
        tick();
        check("rst2_pos", int'(mole_pos), 0);
        check("rst2_valid", int'(mole_valid), 0);
        check("rst2_changed", int'(pos_changed), 0);
        check("rst2_ok", int'(hit_ok), 0);
        check("rst2_miss", int'(miss), 0);
        tick();
        rst_n = 1'b1;
        tick();
        restart = 1'b0;
        await_spawn(2'd0, s, p);
        check("rst2_first_pos", int'(mole_pos), 1);
        expire(s, p, 1'b0);

        // IDLE after reset stays inert without restart
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("idle_valid", int'(mole_valid), 0);
        end
        tick();
        check("events_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Parametrised successor to the single-mole position generator. It drives the whack-a-mole game core with a configurable hole count and a maximal-length LFSR. Per-mole lifetime comes from a base period scaled by difficulty level, and a hidden gap separates consecutive moles. It owns the full mole life cycle (spawn, hit, miss), never repeats a hole back-to-back, and feeds score/display logic with single-cycle event pulses.

## Interface
- NUM_HOLES, 5, number of holes; legal 2..16
- HOLE_W, $clog2(NUM_HOLES), position width (derived; not overridden)
- LFSR_W, 16, LFSR width
- TAPS, 16'hB400, Galois tap mask (right-shift form); must be maximal-length for LFSR_W
- SEED, 16'hACE1, LFSR reset value; nonzero
- BASE_PERIOD, 100000000, mole lifetime in cycles at level 0; >= 8
- GAP_CYCLES, 25000000, hidden time between moles in cycles; >= 1
- i_clk  in  1  system clock; all logic on posedge
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_restart_game  in  1  start or restart the game (level-sensitive)
- i_game_over  in  1  freeze the scheduler
- i_level  in  2  difficulty level 0..3
- i_hit  in  1  whack strobe, one cycle per whack
- i_hit_pos  in  HOLE_W  hole whacked, qualified by i_hit
- o_mole_position  out  HOLE_W  current or last mole hole
- o_mole_valid  out  1  mole currently visible
- o_position_changed  out  1  one-cycle pulse on spawn
- o_hit_ok  out  1  one-cycle pulse: correct hole hit
- o_hit_bad  out  1  one-cycle pulse: wrong hole hit while a mole is visible
- o_miss  out  1  one-cycle pulse: mole expired unhit

## Operation
- States:
  - IDLE: after reset.
  - GAP: mole hidden, counting.
  - SHOW: mole visible, counting.
  - HALT: game over.
- Per-edge priority: reset > restart > game_over > hit > timeout.
- Reset (i_rst_n=0):
  - State IDLE; counter 0; lfsr=SEED; prev=0.
  - o_mole_position=0; o_mole_valid=0; all pulses 0.
- i_restart_game=1 (any state): state GAP, counter 0, o_mole_valid=0, pulses 0. LFSR is not reseeded. Holding restart high keeps the counter at 0.
- i_game_over=1 (not restarting): state HALT, o_mole_valid=0, pulses 0, counter and LFSR frozen. HALT exits only via restart or reset.
- IDLE: inert apart from LFSR stepping; waits for restart.
- LFSR:
  - Steps every cycle except in reset and HALT.
  - Step rule: if lfsr[0], lfsr=(lfsr>>1)^TAPS, else lfsr>>1.
  - An all-zero value (unreachable in normal operation) is forced to SEED.
- GAP: counter increments each cycle. At the edge where counter==GAP_CYCLES-1, the block spawns.
- Spawn:
  - cand = lfsr % NUM_HOLES.
  - pos = (cand==prev) ? (cand+1)%NUM_HOLES : cand.
  - o_mole_position=pos, prev=pos, o_mole_valid=1, o_position_changed=1 for that cycle.
  - Latch period = BASE_PERIOD >> i_level; counter 0; state SHOW.
- SHOW, hit:
  - i_hit with i_hit_pos==o_mole_position: o_hit_ok pulse, o_mole_valid=0, state GAP, counter 0.
  - i_hit with any other i_hit_pos: o_hit_bad pulse; no state, counter or valid change.
- SHOW, timeout: at the edge where counter==period-1 with no correct hit, o_miss pulse, o_mole_valid=0, state GAP, counter 0.
- A correct hit and a timeout on the same edge: hit wins; o_hit_ok only, no o_miss.
- i_hit outside SHOW is ignored (no pulse).
- Mid-life level change: i_level is sampled only at spawn. A change during SHOW affects the next mole only.
- o_mole_position holds its value after the mole hides, until the next spawn.
- Widths:
  - Counter is $clog2(max(BASE_PERIOD,GAP_CYCLES)+1) bits and never wraps.
  - Modulo is computed on the full LFSR_W value.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Restart sampled at edge k, released at k+1: spawn edge is k+GAP_CYCLES; o_position_changed is high for the cycle after that edge.
- Unhit mole: o_mole_valid high for exactly period cycles; o_miss coincides with the first cycle of o_mole_valid=0.
- Hit sampled at edge j: o_hit_ok and o_mole_valid=0 visible after edge j. The next spawn is at edge j+GAP_CYCLES.
- Pulses are exactly one cycle wide and never back-to-back for the same mole.

## Test plan
Bench parameters: NUM_HOLES=5, BASE_PERIOD=16, GAP_CYCLES=4, SEED=16'hACE1.
- Reset then restart pulse at edge 0, level 0, no hits -> spawn at edge 4 with pos = (0xACE1 advanced 4 steps)%5 (skipped if equal to 0). Mole valid 16 cycles, o_miss, next spawn 4 cycles later.
- Run 200 spawns with random levels -> no two consecutive positions equal; all positions <5. Lifetimes 16/8/4/2 match the level sampled at spawn.
- Correct hit at counter==5 -> o_hit_ok one cycle, valid drops, no o_miss. Wrong-hole hit earlier -> o_hit_bad only, lifetime unchanged.
- Correct hit on the timeout edge (counter==15) -> o_hit_ok=1, o_miss=0.
- i_game_over asserted mid-SHOW for 10 cycles -> valid 0, LFSR and counter frozen, no pulses. Restart -> GAP from 0, spawn 4 edges later.
- i_rst_n low mid-SHOW with i_restart_game also high -> all outputs 0, state IDLE, lfsr=SEED. Reset dominates restart.
